// File: rtl/led_ripple_checker.sv
// Receive-side monitor for the 8-LED ripple: checks that one lit LED advances one
// position every STEP_CYCLES clocks (+/- TOL), tracks lock, position and counters.
module led_ripple_checker #(
  parameter int STEP_CYCLES = 4,
  parameter int TOL         = 0,
  parameter int DIR         = 0,
  parameter int LOCK_STEPS  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led0,
  input  logic        led1,
  input  logic        led2,
  input  logic        led3,
  input  logic        led4,
  input  logic        led5,
  input  logic        led6,
  input  logic        led7,
  output logic        locked,
  output logic        error,
  output logic [7:0]  err_count,
  output logic [15:0] step_count,
  output logic [2:0]  cur_pos
);

  localparam int MAXD = STEP_CYCLES + TOL;
  localparam int MIND = STEP_CYCLES - TOL;
  localparam int DW   = $clog2(MAXD + 2);

  typedef enum logic [1:0] {SEARCH, SYNC, TRACK, LOCKED} state_t;

  state_t          state_q;
  logic [7:0]      v_q, prev_q;
  logic [2:0]      pos_q;
  logic [DW-1:0]   dwell_q;
  logic [3:0]      good_q;
  logic [7:0]      err_q;
  logic [15:0]     step_q;
  logic            error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 8'd0;
      prev_q <= 8'd0;
    end else begin
      v_q    <= {led7, led6, led5, led4, led3, led2, led1, led0};
      prev_q <= v_q;
    end
  end

  logic          onehot, chg, step_ok, in_win, stall, adv, flt;
  logic [2:0]    idx, exp_pos;
  logic [3:0]    good_nx;
  logic [DW-1:0] dwell_inc;

  assign onehot    = (v_q != 8'd0) && ((v_q & (v_q - 8'd1)) == 8'd0);
  assign exp_pos   = (DIR != 0) ? pos_q - 3'd1 : pos_q + 3'd1;
  assign chg       = (v_q != prev_q);
  assign step_ok   = onehot && (idx == exp_pos);
  assign in_win    = (dwell_q >= DW'(MIND)) && (dwell_q <= DW'(MAXD));
  // A stall is flagged on the clock that would push dwell past the window.
  assign stall     = (dwell_q >= DW'(MAXD));
  assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + DW'(1);
  assign good_nx   = (&good_q) ? good_q : good_q + 4'd1;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v_q[i]) idx = 3'(i);
  end

  always_comb begin
    adv = 1'b0;
    flt = 1'b0;
    case (state_q)
      SYNC: begin
        adv = chg && step_ok;
        flt = chg && !step_ok;
      end
      TRACK, LOCKED: begin
        adv = chg && step_ok && in_win;
        flt = chg ? !(step_ok && in_win) : stall;
      end
      default: ;
    endcase
  end

  // Dwell in SYNC is unchecked: acquisition may land mid-dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      pos_q   <= 3'd0;
      dwell_q <= '0;
      good_q  <= 4'd0;
      err_q   <= 8'd0;
      step_q  <= 16'd0;
      error_q <= 1'b0;
    end else begin
      error_q <= flt;
      if (flt) begin
        state_q <= SEARCH;
        good_q  <= 4'd0;
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end else if (adv) begin
        pos_q   <= idx;
        dwell_q <= DW'(1);
        step_q  <= step_q + 16'd1;
        good_q  <= good_nx;
        state_q <= (good_nx >= 4'(LOCK_STEPS)) ? LOCKED : TRACK;
      end else begin
        case (state_q)
          SEARCH: if (onehot) begin
            state_q <= SYNC;
            pos_q   <= idx;
            dwell_q <= DW'(1);
            good_q  <= 4'd0;
          end
          default: if (!chg) dwell_q <= dwell_inc;
        endcase
      end
    end
  end

  assign locked     = (state_q == LOCKED);
  assign error      = error_q;
  assign err_count  = err_q;
  assign step_count = step_q;
  assign cur_pos    = pos_q;

endmodule

// File: tb/tb_led_ripple_checker.sv
// Bench for led_ripple_checker: LED stimulus as (value, dwell) segments, checked
// against a segment-level reference of the ripple rules on two configurations.
module tb_led_ripple_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  leds [2];
  logic        lk [2];
  logic        er [2];
  logic [7:0]  ec [2];
  logic [15:0] sc [2];
  logic [2:0]  cp [2];

  led_ripple_checker #(.STEP_CYCLES(4), .TOL(0), .DIR(0), .LOCK_STEPS(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .led0(leds[0][0]), .led1(leds[0][1]), .led2(leds[0][2]), .led3(leds[0][3]),
    .led4(leds[0][4]), .led5(leds[0][5]), .led6(leds[0][6]), .led7(leds[0][7]),
    .locked(lk[0]), .error(er[0]), .err_count(ec[0]), .step_count(sc[0]), .cur_pos(cp[0]));

  led_ripple_checker #(.STEP_CYCLES(5), .TOL(1), .DIR(1), .LOCK_STEPS(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .led0(leds[1][0]), .led1(leds[1][1]), .led2(leds[1][2]), .led3(leds[1][3]),
    .led4(leds[1][4]), .led5(leds[1][5]), .led6(leds[1][6]), .led7(leds[1][7]),
    .locked(lk[1]), .error(er[1]), .err_count(ec[1]), .step_count(sc[1]), .cur_pos(cp[1]));

  int n_chk = 0;
  int n_pass = 0;
  int pulses [2] = '{0, 0};

  always @(posedge clk) begin
    if (er[0] === 1'b1) pulses[0] <= pulses[0] + 1;
    if (er[1] === 1'b1) pulses[1] <= pulses[1] + 1;
  end

  // Reference: 0 = searching, 1 = acquired (dwell unchecked), 2 = tracking.
  int p_min [2] = '{4, 4};
  int p_max [2] = '{4, 6};
  int p_dir [2] = '{0, 1};
  int p_lock [2] = '{2, 3};
  int m_st [2], m_pos [2], m_good [2], m_err [2], m_step [2], m_prevL [2];
  int m_tot [2] = '{0, 0};

  function automatic void mreset(int d);
    m_st[d] = 0; m_pos[d] = 0; m_good[d] = 0;
    m_err[d] = 0; m_step[d] = 0; m_prevL[d] = 0;
  endfunction

  function automatic int nxt(int d, int p);
    return (p_dir[d] != 0) ? (p + 7) % 8 : (p + 1) % 8;
  endfunction

  function automatic void mflt(int d);
    if (m_err[d] < 255) m_err[d]++;
    m_tot[d]++;
    m_good[d] = 0;
    m_st[d] = 0;
  endfunction

  function automatic void mseg(int d, logic [7:0] val, int len);
    int  ones = 0;
    int  ix = 0;
    bit  len_ok;
    for (int i = 0; i < 8; i++) if (val[i]) begin ones++; ix = i; end
    len_ok = (m_prevL[d] >= p_min[d]) && (m_prevL[d] <= p_max[d]);
    if (m_st[d] != 0) begin
      if (ones == 1 && ix == nxt(d, m_pos[d]) && (m_st[d] == 1 || len_ok)) begin
        m_pos[d] = ix;
        m_step[d] = (m_step[d] + 1) % 65536;
        if (m_good[d] < 15) m_good[d]++;
        m_st[d] = 2;
      end else mflt(d);
    end
    if (m_st[d] == 0 && ones == 1) begin
      m_st[d] = 1; m_pos[d] = ix; m_good[d] = 0;
    end
    if (m_st[d] == 2 && len > p_max[d]) begin
      mflt(d);
      m_st[d] = 1;
    end
    m_prevL[d] = len;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_state(int d, string tag);
    chk($sformatf("%s.d%0d.err_count", tag, d), 32'(ec[d]), 32'(m_err[d]));
    chk($sformatf("%s.d%0d.step_count", tag, d), 32'(sc[d]), 32'(m_step[d]));
    chk($sformatf("%s.d%0d.locked", tag, d), 32'(lk[d]),
        32'((m_st[d] == 2 && m_good[d] >= p_lock[d]) ? 1 : 0));
    chk($sformatf("%s.d%0d.cur_pos", tag, d), 32'(cp[d]), 32'(m_pos[d]));
  endtask

  // Holds val for len clocks; checks the outcome of the previous segment.
  task automatic drive_seg(int d, logic [7:0] val, int len, string tag);
    @(negedge clk);
    leds[d] = val;
    @(negedge clk);
    chk_state(d, tag);
    mseg(d, val, len);
    repeat (len - 2) @(negedge clk);
  endtask

  task automatic ripple(int d, int start, int n, int len, string tag);
    int p = start;
    for (int i = 0; i < n; i++) begin
      drive_seg(d, 8'd1 << p, (len > 0) ? len : $urandom_range(p_min[d], p_max[d]), tag);
      p = nxt(d, p);
    end
  endtask

  task automatic rnd(int d, int n);
    for (int i = 0; i < n; i++) begin
      int         r = $urandom_range(0, 9);
      int         len;
      logic [7:0] val = 8'd1 << nxt(d, m_pos[d]);
      if (r <= 6) len = $urandom_range(p_min[d], p_max[d]);
      else if (r == 7) begin
        val = 8'($urandom_range(0, 255));
        len = $urandom_range(2, p_max[d]);
      end else if (r == 8) len = $urandom_range(2, p_min[d] - 1);
      else len = $urandom_range(p_max[d] + 3, p_max[d] + 6);
      if (val == leds[d]) val = val ^ 8'h81;
      drive_seg(d, val, len, "rnd");
    end
  endtask

  task automatic finish_dut(int d);
    drive_seg(d, 8'h00, 2, "flush");
    repeat (3) @(negedge clk);
    chk_state(d, "final");
    chk($sformatf("final.d%0d.error_pulses", d), 32'(pulses[d]), 32'(m_tot[d]));
  endtask

  initial begin
    leds[0] = 8'($urandom);
    leds[1] = 8'($urandom);
    mreset(0);
    mreset(1);
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.d%0d.locked", d), 32'(lk[d]), 32'd0);
      chk($sformatf("rst.d%0d.error", d), 32'(er[d]), 32'd0);
      chk($sformatf("rst.d%0d.err_count", d), 32'(ec[d]), 32'd0);
      chk($sformatf("rst.d%0d.step_count", d), 32'(sc[d]), 32'd0);
      chk($sformatf("rst.d%0d.cur_pos", d), 32'(cp[d]), 32'd0);
    end
    @(negedge clk);
    leds[0] = 8'h00;
    leds[1] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle.d0.error_pulses", 32'(pulses[0]), 32'd0);
    chk_state(0, "idle");

    ripple(0, 0, 17, 4, "clean");
    chk("clean.step16", 32'(sc[0]), 32'd16);
    chk("clean.locked", 32'(lk[0]), 32'd1);
    chk("clean.wrap_pos", 32'(cp[0]), 32'd0);
    chk("clean.no_error", 32'(pulses[0]), 32'd0);

    ripple(0, 1, 3, 4, "pre_skip");
    drive_seg(0, 8'h20, 4, "skip");
    chk("skip.err_count", 32'(ec[0]), 32'd1);
    chk("skip.unlocked", 32'(lk[0]), 32'd0);
    ripple(0, 6, 2, 4, "relock");
    chk("relock.locked", 32'(lk[0]), 32'd1);
    ripple(0, 0, 2, 4, "run");

    drive_seg(0, 8'h04, 3, "early_seg");
    drive_seg(0, 8'h08, 4, "early");
    chk("early.err_count", 32'(ec[0]), 32'd2);
    ripple(0, 4, 3, 4, "relock2");
    drive_seg(0, 8'h80, 10, "stall");
    chk("stall.err_count", 32'(ec[0]), 32'd3);
    chk("stall.unlocked", 32'(lk[0]), 32'd0);
    ripple(0, 0, 3, 4, "relock3");
    chk("relock3.locked", 32'(lk[0]), 32'd1);
    drive_seg(0, 8'h0C, 4, "multihot");
    chk("multihot.err_count", 32'(ec[0]), 32'd4);
    ripple(0, 5, 3, 4, "relock4");
    drive_seg(0, 8'h00, 4, "alloff");
    chk("alloff.err_count", 32'(ec[0]), 32'd5);

    rnd(0, 60);

    for (int i = 0; i < 130; i++) begin
      drive_seg(0, 8'h01, 2, "sat");
      drive_seg(0, 8'h08, 2, "sat");
    end
    chk("sat.err_count", 32'(ec[0]), 32'd255);

    drive_seg(0, 8'h00, 3, "pre_rst");
    ripple(0, 4, 3, 4, "pre_rst");
    chk("midrst.locked_before", 32'(lk[0]), 32'd1);
    chk("midrst.pos_before", 32'(cp[0]), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.locked", 32'(lk[0]), 32'd0);
    chk("midrst.err_count", 32'(ec[0]), 32'd0);
    chk("midrst.step_count", 32'(sc[0]), 32'd0);
    chk("midrst.cur_pos", 32'(cp[0]), 32'd0);
    @(negedge clk);
    leds[0] = 8'h00;
    mreset(0);
    mreset(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ripple(0, 0, 4, 4, "reacq");
    chk("reacq.locked", 32'(lk[0]), 32'd1);
    finish_dut(0);

    ripple(1, 7, 10, 0, "d1_clean");
    chk("d1_clean.locked", 32'(lk[1]), 32'd1);
    drive_seg(1, 8'd1 << nxt(1, m_pos[1]), 3, "d1_early_seg");
    drive_seg(1, 8'd1 << nxt(1, m_pos[1]), 5, "d1_early");
    chk("d1_early.err_count", 32'(ec[1]), 32'd1);
    ripple(1, nxt(1, m_pos[1]), 5, 0, "d1_relock");
    rnd(1, 80);
    finish_dut(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
